// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared widths, result entry type and product assembly for the
//             4x4 signed Booth multiplier result path.       rev 1.0
// ============================================================================
package booth_pkg;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 5;
    localparam int Q_W    = 5;

    typedef struct packed {
        logic              err;
        logic [PROD_W-1:0] prod;
    } result_entry_t;

    // q[0] is the Booth Q-1 bookkeeping bit and carries no product weight.
    function automatic result_entry_t assemble_product(
        input logic [ACC_W-1:0] acc,
        input logic [Q_W-1:0]   q
    );
        result_entry_t e;
        logic          unused_qm1;
        unused_qm1 = q[0];
        e.err      = acc[4] ^ acc[3];
        e.prod     = {acc[3:0], q[4:1]};
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_result_fifo.sv
`default_nettype none
// ============================================================================
// booth_result_fifo : generic first-word-fall-through FIFO with occupancy.
//                     rev 1.0
// ============================================================================
module booth_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH+1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic [WIDTH-1:0]    r_hold;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // r_hold keeps the last presented head so the read port is stable when empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_BITS'(1);
                2'b01:   r_count <= r_count - CNT_BITS'(1);
                default: r_count <= r_count;
            endcase
            if (!o_empty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_BITS'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = o_empty ? r_hold : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/booth_result_collector.sv
`default_nettype none
// ============================================================================
// booth_result_collector : captures Booth products on done rising edges and
//                          queues them for a valid/ready consumer.  rev 1.0
// ============================================================================
module booth_result_collector #(
    parameter int DEPTH  = 4,
    parameter int PROD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_assert_done,
    input  logic [booth_pkg::ACC_W-1:0]   i_acc_out,
    input  logic [booth_pkg::Q_W-1:0]     i_q_out,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [PROD_W-1:0]             o_result,
    output logic                          o_err,
    output logic                          o_full,
    output logic [$clog2(DEPTH+1)-1:0]    o_count,
    output logic                          o_drop,
    output logic [CNT_W-1:0]              o_total
);

    import booth_pkg::result_entry_t;
    import booth_pkg::assemble_product;

    logic             r_done_d;
    logic             r_drop;
    logic [CNT_W-1:0] r_total;

    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    result_entry_t    w_entry;
    result_entry_t    w_head;

    // r_done_d resets high so a done level held through reset is not a new product.
    assign w_push_req = i_assert_done & ~r_done_d;
    assign w_entry    = assemble_product(i_acc_out, i_q_out);
    assign w_pop      = ~w_empty & i_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);

    booth_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(result_entry_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_d <= 1'b1;
            r_drop   <= 1'b0;
            r_total  <= '0;
        end else begin
            r_done_d <= i_assert_done;
            r_drop   <= w_push_req & w_full & ~w_pop;
            if (w_push) begin
                r_total <= r_total + CNT_W'(1);
            end
        end
    end

    assign o_valid  = ~w_empty;
    assign o_full   = w_full;
    assign o_result = w_head.prod;
    assign o_err    = w_head.err;
    assign o_drop   = r_drop;
    assign o_total  = r_total;

endmodule
`default_nettype wire

// File: doc/booth_result_collector.md
Name: booth_result_collector

Overview:
- Downstream stage of the 4-bit signed Booth multiplier top design.
- Watches the multiplier's done flag and, on each completed multiply, assembles the 8-bit signed product from the ACC and Q registers.
- Checks sign consistency of the product and queues it in a small first-word-fall-through FIFO.
- Presents queued results on a valid/ready interface to the consumer, with full/drop status back to the operand sequencer.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PROD_W, 8, product width; fixed at 8 for the 4x4 signed multiplier.
- CNT_W, 8, width of the running accepted-result counter; wraps.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_assert_done  in  1  multiplier done level; a rising edge marks a completed product.
- i_acc_out  in  5  multiplier ACC register.
- i_q_out  in  5  multiplier Q register; bit 0 is the Booth Q-1 bit.
- i_ready  in  1  consumer ready.
- o_valid  out  1  head entry available.
- o_result  out  PROD_W  head product, signed.
- o_err  out  1  head entry sign-check error flag.
- o_full  out  1  FIFO full; the sequencer must not start a new multiply while high.
- o_count  out  clog2(DEPTH+1)  current occupancy.
- o_drop  out  1  one-cycle pulse: a product was discarded because the FIFO was full.
- o_total  out  CNT_W  count of accepted products, wraps to 0.

Behaviour:
- Reset (async assert, sync release): FIFO empty; rd/wr pointers 0; o_valid=0, o_result=0, o_err=0, o_full=0, o_count=0, o_drop=0, o_total=0; done_d=1.
- Edge detect: done_d registers i_assert_done every cycle. push_req = i_assert_done & ~done_d.
  - done_d resets to 1, so a done held high across reset release produces no capture; done must fall and rise again.
- Product assembly (combinational, sampled on push_req): prod = {i_acc_out[3:0], i_q_out[4:1]}; err = i_acc_out[4] ^ i_acc_out[3].
  - Entry stores {err, prod}, 9 bits.
- Push: push_req & (~full | pop) -> write entry at wr_ptr, wr_ptr++, o_total++. Latency: the entry is visible at o_result/o_valid on the cycle after the done edge is sampled.
- Drop: push_req & full & ~pop -> entry discarded; o_drop=1 for exactly one cycle; pointers, count and o_total unchanged.
- Pop: pop = o_valid & i_ready -> rd_ptr++. o_result/o_err always show the entry at rd_ptr.
  - When empty, o_result and o_err hold their last values; contents are don't-care, but o_valid=0.
- Simultaneous push and pop:
  - Count unchanged; allowed even when full, where pop frees the slot that push uses.
  - When empty, only push applies, because pop requires o_valid.
- Pointers: clog2(DEPTH) bits, wrap modulo DEPTH. count tracks occupancy. o_full = (count==DEPTH); o_valid = (count!=0).
- o_total wraps from 2^CNT_W-1 to 0 with no flag.
- Async reset mid-stream: all queued entries are lost immediately and outputs return to reset values.
- No X-propagation from unused entries: the memory is not reset, so the bench checks o_result only when o_valid=1.

Decomposition:
- Shared package booth_pkg holds:
  - PROD_W=8, ACC_W=5, Q_W=5.
  - typedef result_entry_t {logic err; logic [PROD_W-1:0] prod;}.
  - Function assemble_product(acc, q), reused by the top-level testbench.
- One sub-module, booth_result_fifo: generic FWFT FIFO (DEPTH, WIDTH) with push/pop/full/empty/count.
- The collector wraps booth_result_fifo with edge detect, assembly, drop and total logic.

Test Plan:
- -8 x -7: after a done rise with acc=5'b00011, q=5'b10000 -> o_valid next cycle, o_result=8'h38 (56), o_err=0, o_total=1.
- 3 x -7: acc=5'b11110, q=5'b10110 -> o_result=8'hEB (-21), o_err=0. Then acc=5'b01110 -> o_err=1.
- Done held high 10 cycles -> exactly one entry. Done high during reset release -> zero entries until a fresh rising edge.
- Fill 4 entries with i_ready=0 -> o_full=1, o_count=4. Fifth done edge -> o_drop one-cycle pulse, o_total stays 4. Drain -> data returned in order, o_valid drops after the 4th pop.
- Full with i_ready=1 and a done edge in the same cycle -> push accepted, o_drop=0, o_count stays 4, ordering preserved.
- Assert i_rst_n low mid-drain with 3 entries queued -> outputs return to reset values asynchronously. Next done edge after release -> o_count=1, o_total=1.
